mux_sel_rr_sequencer: RTL and testbench

//  Round-robin select sequencer sitting directly upstream of the 4:1 bit mux.

---
 rtl/mux_sel_rr_sequencer_if.sv | 20 ++
 rtl/mux_sel_rr_sequencer.sv | 88 ++++++++
 tb/tb_mux_sel_rr_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mux_sel_rr_sequencer_if.sv
// rtl/mux_sel_rr_sequencer_if.sv - request/select/grant bundle between channel sources, mux and sequencer
interface mux_sel_rr_sequencer_if;
  logic [3:0] req;
  logic       out_ready;
  logic       s0;
  logic       s1;
  logic [3:0] grant;
  logic       out_valid;
  logic       busy;

  modport master (
    output req, out_ready,
    input  s0, s1, grant, out_valid, busy
  );

  modport slave (
    input  req, out_ready,
    output s0, s1, grant, out_valid, busy
  );
endinterface

// File: rtl/mux_sel_rr_sequencer.sv
// rtl/mux_sel_rr_sequencer.sv - round-robin 4:1 mux select sequencer with per-grant dwell limit
module mux_sel_rr_sequencer #(
  parameter int DWELL_MAX = 4,
  parameter int CNT_W     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mux_sel_rr_sequencer_if.slave  bus
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t           state_q;
  logic [1:0]       sel_q;
  logic [1:0]       ptr_q;
  logic [3:0]       grant_q;
  logic             valid_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0]       win_d;
  logic             transfer;
  logic             last_beat;
  logic             req_drop;

  // Search starts one past the last winner, so the last winner is tried last.
  always_comb begin
    logic found;
    win_d = ptr_q;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!found && bus.req[ptr_q + 2'(i)]) begin
        win_d = ptr_q + 2'(i);
        found = 1'b1;
      end
    end
  end

  assign transfer  = valid_q & bus.out_ready;
  assign last_beat = transfer && (cnt_q == CNT_W'(DWELL_MAX - 1));
  assign req_drop  = !bus.req[sel_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
      grant_q <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req != 4'd0) begin
            state_q <= SERVE;
            sel_q   <= win_d;
            ptr_q   <= win_d;
            grant_q <= 4'd1 << win_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        SERVE: begin
          // A beat presented while the request drops is still accepted on exit.
          if (last_beat || req_drop) begin
            state_q <= IDLE;
            grant_q <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (transfer) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s0        = sel_q[1];
  assign bus.s1        = sel_q[0];
  assign bus.grant     = grant_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mux_sel_rr_sequencer.sv
// tb/tb_mux_sel_rr_sequencer.sv - directed bench for the round-robin mux select sequencer
module tb_mux_sel_rr_sequencer;
  localparam int DW = 4;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  mux_sel_rr_sequencer_if ifc ();

  mux_sel_rr_sequencer #(.DWELL_MAX(DW), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] g, input logic [1:0] sel,
                       input logic v, input logic b);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {ifc.grant, ifc.s0, ifc.s1, ifc.out_valid, ifc.busy};
    exp = {g, sel, v, b};
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed grant/sel/valid/busy=%b required %b", tag, obs, exp);
    end
  endtask

  // Called right after the arbitration edge with out_ready high throughout.
  task automatic serve_full(input string tag, input logic [1:0] ch);
    for (int b = 0; b < DW; b++) begin
      check(tag, 4'd1 << ch, ch, 1'b1, 1'b1);
      step();
    end
    check({tag, "_idle"}, 4'd0, ch, 1'b0, 1'b0);
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    ifc.req       = 4'b1111;
    ifc.out_ready = 1'b1;

    // T1 reset
    step();
    step();
    check("t1_reset", 4'd0, 2'd0, 1'b0, 1'b0);
    ifc.req = 4'b0000;
    rst_n   = 1'b1;
    step();
    check("t1_idle_noreq", 4'd0, 2'd0, 1'b0, 1'b0);

    // T2 single channel, full dwell, mandatory idle slot, re-grant
    ifc.req = 4'b0100;
    step();
    serve_full("t2_first", 2'd2);
    step();
    check("t2_regrant", 4'b0100, 2'd2, 1'b1, 1'b1);
    ifc.req = 4'b0000;
    step();
    check("t2_drop_exit", 4'd0, 2'd2, 1'b0, 1'b0);

    // T3 rotation from fresh reset
    rst_n = 1'b0;
    #1;
    check("t3_reset", 4'd0, 2'd0, 1'b0, 1'b0);
    step();
    rst_n   = 1'b1;
    ifc.req = 4'b1111;
    step();
    serve_full("t3_ch0", 2'd0);
    step();
    serve_full("t3_ch1", 2'd1);
    step();
    serve_full("t3_ch2", 2'd2);
    step();
    serve_full("t3_ch3", 2'd3);
    step();
    check("t3_wrap_ch0", 4'b0001, 2'd0, 1'b1, 1'b1);
    ifc.req = 4'b0000;
    step();
    check("t3_exit", 4'd0, 2'd0, 1'b0, 1'b0);

    // T4 backpressure freezes the dwell count
    ifc.req = 4'b0010;
    step();
    check("t4_grant", 4'b0010, 2'd1, 1'b1, 1'b1);
    step();
    step();
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t4_stall_hold", 4'b0010, 2'd1, 1'b1, 1'b1);
    end
    ifc.out_ready = 1'b1;
    step();
    check("t4_beat3", 4'b0010, 2'd1, 1'b1, 1'b1);
    step();
    check("t4_after_beat4", 4'd0, 2'd1, 1'b0, 1'b0);
    ifc.req = 4'b0000;
    step();

    // T5 request drop mid-grant
    ifc.req = 4'b1000;
    step();
    check("t5_grant", 4'b1000, 2'd3, 1'b1, 1'b1);
    step();
    ifc.req = 4'b0000;
    step();
    check("t5_drop", 4'd0, 2'd3, 1'b0, 1'b0);
    step();
    check("t5_stay_idle", 4'd0, 2'd3, 1'b0, 1'b0);

    // T6 async reset mid-SERVE on ch1
    ifc.req = 4'b0010;
    step();
    check("t6_grant_ch1", 4'b0010, 2'd1, 1'b1, 1'b1);
    ifc.req = 4'b1111;
    step();
    check("t6_others_ignored", 4'b0010, 2'd1, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", 4'd0, 2'd0, 1'b0, 1'b0);
    step();
    check("t6_held_reset", 4'd0, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    check("t6_first_after_reset", 4'b0001, 2'd0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
